score_keeper: RTL and testbench
===============================

# score_keeper

Upstream stage of the seven-segment decoder in the Pong display path. Tracks both players' scores in BCD, runs the game state (idle / play / game over) and time-multiplexes four score digits onto one 4-bit `o_num` bus for the registered seven-segment decoder. It also drives one-hot digit enables, aligned to the decoder's one-cycle latency.

## Interface
- `WIN_SCORE`, 11: score that ends the game; legal range 1..99.
- `REFRESH_DIV`, 25000: `i_clk` cycles per digit slot; legal range ≥ 2.
- `BLINK_DIV`, 12500000: `i_clk` cycles per blink half-period; used only with `SCORE_BLINK_EN`.
- `i_clk` input 1: single system clock; all state on its rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_p1_point` input 1: level, high while P1 scores (ball passed P2); rising edge counted.
- `i_p2_point` input 1: level, high while P2 scores; rising edge counted.
- `i_game_start` input 1: level; a rising edge starts or restarts a game.
- `o_num` output 4: BCD digit for the decoder, always 0..9.
- `o_digit_en` output 4: one-hot digit enable, active-high. Bit 3 = P1 tens, bit 2 = P1 ones, bit 1 = P2 tens, bit 0 = P2 ones.
- `o_game_over` output 1: high in GAME_OVER.
- `o_winner` output 2: 00 none, 01 P1, 10 P2, 11 tie.

## Operation
- All three inputs are edge-detected with one registered previous-value flop each. An event is current high and previous low. Previous-value flops reset to 0.
- Scores are held as two BCD digit pairs (tens, ones) per player.
- Increment: ones 9→0 with tens+1; otherwise ones+1. Scores never exceed `WIN_SCORE`.
- FSM states:
  - IDLE (reset): scores 0; point events are ignored. A start event goes to PLAY.
  - PLAY: each point event increments that player's score. Both events in the same cycle increment both scores. If either post-increment score equals `WIN_SCORE`, go to GAME_OVER. `o_winner` is 01/10 by which player reached it, or 11 if both reached it in the same cycle. A start event in PLAY clears the scores and stays in PLAY.
  - GAME_OVER: scores are frozen and point events are ignored. A start event clears the scores and `o_winner` and goes to PLAY.
- A start event in the same cycle as a point event: start wins and the point is dropped.
- Display mux:
  - Refresh counter counts 0..`REFRESH_DIV`-1 and then wraps.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0. Index 0 = P1 tens, 1 = P1 ones, 2 = P2 tens, 3 = P2 ones.
  - `o_num` is registered from the digit selected by the index.
  - `o_digit_en` is the index decoded one-hot, registered one cycle later than `o_num`. This matches the decoder's registered latency, so segments and enable change on the same edge.
  - Leading zeros are displayed (score 7 shows "07").
- Display runs in every state. IDLE shows 00 00.

## Timing
- Reset values (asynchronous): state IDLE, all score digits 0, `o_num`=0, `o_digit_en`=4'b1000, `o_game_over`=0, `o_winner`=00, refresh counter 0, digit index 0, blink counter 0.
- Point input rising edge at cycle N: edge is seen at N+1 and the score register updates at N+1.
- Score change reaches `o_num` by the next time that digit is selected. Worst case is 4×`REFRESH_DIV` cycles.
- `o_game_over` and `o_winner` assert in the same cycle as the winning score update.
- Reset mid-game: immediate return to reset values, with no stale point counted after release. Edge flops reset to 0, so an input already high at release counts as an edge on the first clock.

## Configuration
- `SCORE_BLINK_EN` defined:
  - In GAME_OVER, a blink counter toggles a phase bit every `BLINK_DIV` cycles.
  - While the phase bit is 1, the winner's two `o_digit_en` bits are forced to 0. On a tie, all four are forced to 0.
  - `o_num` is unaffected. The blink counter and phase clear on leaving GAME_OVER.
- `SCORE_BLINK_EN` undefined: no blink logic; all digits are steady in every state.

## Test plan
- Reset with `i_rst` pulsed mid-count → all outputs at reset values asynchronously; after release, `o_digit_en` cycles 1000→0100→0010→0001, `o_num`=0 throughout.
- Start, then P1 point high for 5 cycles → P1 score 01 (a single increment); `o_num`=1 appears on index 1 with `o_digit_en`=0100 one cycle after.
- Start, then P2 points ×10 → P2 tens=1, ones=0; display shows 10.
- `WIN_SCORE`=11, scores 10/10, P1 and P2 edges in the same cycle → both 11, `o_game_over`=1, `o_winner`=11; further points ignored.
- Score 3/2, start edge coincident with P1 edge → scores 0/0, state PLAY, point dropped.
- With `SCORE_BLINK_EN`, `BLINK_DIV`=4, P2 wins → `o_digit_en` bits 1:0 masked for 4 cycles and unmasked for 4 cycles alternately; without the macro, no masking.

Source files
------------

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Brief    : Pong score tracking (BCD), game FSM and 4-digit display mux
//            feeding a registered seven-segment decoder.
//            Optional winner blink enabled by defining SCORE_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned REFRESH_DIV = 25000,
    parameter int unsigned BLINK_DIV   = 12500000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_p1_point,
    input  logic       i_p2_point,
    input  logic       i_game_start,
    output logic [3:0] o_num,
    output logic [3:0] o_digit_en,
    output logic       o_game_over,
    output logic [1:0] o_winner
);

    localparam int unsigned              c_refresh_w   = $clog2(REFRESH_DIV);
    localparam logic [c_refresh_w-1:0]   c_refresh_max = c_refresh_w'(REFRESH_DIV - 1);
    localparam logic [7:0]               c_win_bcd     = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    // BCD increment of a {tens, ones} pair
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s[3:0] == 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_p1_score;
    logic [7:0] r_p2_score;
    logic [7:0] w_p1_score_nxt;
    logic [7:0] w_p2_score_nxt;
    logic [1:0] r_winner;
    logic [1:0] w_winner_nxt;
    logic       r_game_over;

    logic       r_p1_prev;
    logic       r_p2_prev;
    logic       r_start_prev;
    logic       w_p1_evt;
    logic       w_p2_evt;
    logic       w_start_evt;
    logic [7:0] w_p1_inc;
    logic [7:0] w_p2_inc;
    logic       w_p1_hit;
    logic       w_p2_hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p1_prev    <= 1'b0;
            r_p2_prev    <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_p1_prev    <= i_p1_point;
            r_p2_prev    <= i_p2_point;
            r_start_prev <= i_game_start;
        end
    end

    assign w_p1_evt    = i_p1_point & ~r_p1_prev;
    assign w_p2_evt    = i_p2_point & ~r_p2_prev;
    assign w_start_evt = i_game_start & ~r_start_prev;

    assign w_p1_inc = bcd_inc(r_p1_score);
    assign w_p2_inc = bcd_inc(r_p2_score);
    assign w_p1_hit = w_p1_evt && (w_p1_inc == c_win_bcd);
    assign w_p2_hit = w_p2_evt && (w_p2_inc == c_win_bcd);

    // ------------------------------------------------------------------
    // Game FSM: state register plus next-state / score logic
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_p1_score  <= 8'd0;
            r_p2_score  <= 8'd0;
            r_winner    <= 2'b00;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_p1_score  <= w_p1_score_nxt;
            r_p2_score  <= w_p2_score_nxt;
            r_winner    <= w_winner_nxt;
            r_game_over <= (w_state_nxt == ST_GAME_OVER);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_p1_score_nxt = r_p1_score;
        w_p2_score_nxt = r_p2_score;
        w_winner_nxt   = r_winner;
        case (r_state)
            ST_IDLE: begin
                if (w_start_evt) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A start in the same cycle as a point drops the point
                if (w_start_evt) begin
                    w_p1_score_nxt = 8'd0;
                    w_p2_score_nxt = 8'd0;
                end else begin
                    if (w_p1_evt) begin
                        w_p1_score_nxt = w_p1_inc;
                    end
                    if (w_p2_evt) begin
                        w_p2_score_nxt = w_p2_inc;
                    end
                    if (w_p1_hit || w_p2_hit) begin
                        w_state_nxt  = ST_GAME_OVER;
                        w_winner_nxt = {w_p2_hit, w_p1_hit};
                    end
                end
            end
            ST_GAME_OVER: begin
                if (w_start_evt) begin
                    w_state_nxt    = ST_PLAY;
                    w_p1_score_nxt = 8'd0;
                    w_p2_score_nxt = 8'd0;
                    w_winner_nxt   = 2'b00;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_p1_score_nxt = 8'd0;
                w_p2_score_nxt = 8'd0;
                w_winner_nxt   = 2'b00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Winner blink mask for o_digit_en
    // ------------------------------------------------------------------
    logic [3:0] w_blink_mask;

`ifdef SCORE_BLINK_EN
    localparam int unsigned            c_blink_w   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_blink_w-1:0]   c_blink_max = c_blink_w'(BLINK_DIV - 1);

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_phase;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_state != ST_GAME_OVER) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == c_blink_max) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    always_comb begin
        w_blink_mask = 4'b0000;
        if (r_blink_phase) begin
            case (r_winner)
                2'b01:   w_blink_mask = 4'b1100;
                2'b10:   w_blink_mask = 4'b0011;
                2'b11:   w_blink_mask = 4'b1111;
                default: w_blink_mask = 4'b0000;
            endcase
        end
    end
`else
    // No blinking; an illegal zero BLINK_DIV blanks the display so it gets noticed
    assign w_blink_mask = {4{BLINK_DIV == 0}};
`endif

    // ------------------------------------------------------------------
    // Display multiplexer
    // ------------------------------------------------------------------
    logic [c_refresh_w-1:0] r_refresh_cnt;
    logic [1:0]             r_digit_idx;
    logic [1:0]             r_idx_d1;
    logic [3:0]             r_num;
    logic [3:0]             r_digit_en;
    logic [3:0]             w_digit_sel;

    always_comb begin
        w_digit_sel = 4'd0;
        case (r_digit_idx)
            2'd0:    w_digit_sel = r_p1_score[7:4];
            2'd1:    w_digit_sel = r_p1_score[3:0];
            2'd2:    w_digit_sel = r_p2_score[7:4];
            2'd3:    w_digit_sel = r_p2_score[3:0];
            default: w_digit_sel = 4'd0;
        endcase
    end

    // Enable trails o_num by one cycle to line up with the decoder register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= 2'd0;
            r_idx_d1      <= 2'd0;
            r_num         <= 4'd0;
            r_digit_en    <= 4'b1000;
        end else begin
            if (r_refresh_cnt == c_refresh_max) begin
                r_refresh_cnt <= '0;
                r_digit_idx   <= r_digit_idx + 2'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
            r_num      <= w_digit_sel;
            r_idx_d1   <= r_digit_idx;
            r_digit_en <= (4'b1000 >> r_idx_d1) & ~w_blink_mask;
        end
    end

    assign o_num       = r_num;
    assign o_digit_en  = r_digit_en;
    assign o_game_over = r_game_over;
    assign o_winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_keeper
// Brief    : Self-checking bench for score_keeper with a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    localparam int WIN  = 11;
    localparam int RDIV = 4;
    localparam int S_IDLE = 0, S_PLAY = 1, S_OVER = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       p1, p2, start;
    logic [3:0] num, en;
    logic       go;
    logic [1:0] win;

    score_keeper #(
        .WIN_SCORE  (WIN),
        .REFRESH_DIV(RDIV),
        .BLINK_DIV  (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_p1_point  (p1),
        .i_p2_point  (p2),
        .i_game_start(start),
        .o_num       (num),
        .o_digit_en  (en),
        .o_game_over (go),
        .o_winner    (win)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: integer scores, game state, and clock count since reset
    int         m_p1, m_p2, m_state, m_n;
    logic [1:0] m_winner;
    logic       m_go;
    logic [3:0] m_num, m_en;
    logic       m_prev1, m_prev2, m_prevs;

    function automatic int digit_of(input int k);
        case (k)
            0:       return m_p1 / 10;
            1:       return m_p1 % 10;
            2:       return m_p2 / 10;
            default: return m_p2 % 10;
        endcase
    endfunction

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_state = S_IDLE; m_n = 0;
        m_winner = 2'b00; m_go = 1'b0; m_num = 4'd0; m_en = 4'b1000;
        m_prev1 = 1'b0; m_prev2 = 1'b0; m_prevs = 1'b0;
    endtask

    // Predict outputs after the coming rising edge from the inputs now applied
    task automatic model_step();
        int  idx_now, idx_prev;
        bit  e1, e2, es, h1, h2;
        idx_now  = (m_n / RDIV) % 4;
        idx_prev = (m_n == 0) ? 0 : ((m_n - 1) / RDIV) % 4;
        m_num = 4'(digit_of(idx_now));
        m_en  = 4'(8 >> idx_prev);
        e1 = p1 && !m_prev1;
        e2 = p2 && !m_prev2;
        es = start && !m_prevs;
        if (es) begin
            m_p1 = 0; m_p2 = 0; m_winner = 2'b00; m_state = S_PLAY;
        end else if (m_state == S_PLAY) begin
            if (e1) m_p1++;
            if (e2) m_p2++;
            h1 = e1 && (m_p1 == WIN);
            h2 = e2 && (m_p2 == WIN);
            if (h1 || h2) begin
                m_state  = S_OVER;
                m_winner = {h2, h1};
            end
        end
        m_go    = (m_state == S_OVER);
        m_prev1 = p1; m_prev2 = p2; m_prevs = start;
        m_n++;
    endtask

    task automatic compare_outputs();
        check("o_num", num, m_num);
        check("o_digit_en", en, m_en);
        check("o_game_over", go, m_go);
        check("o_winner", win, m_winner);
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        compare_outputs();
        if (!rst) model_step();
    end

    // Stimulus moves 2 time units after each rising edge
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic point(input bit a, input bit b);
        p1 = a; p2 = b;
        tick(1);
        p1 = 1'b0; p2 = 1'b0;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
    endtask

    // Wait for o_digit_en to newly select tgt, then check the digit shown
    task automatic show(input logic [3:0] tgt, input logic [3:0] want, input string name);
        int k = 0;
        while (en == tgt && k < 40) begin tick(1); k++; end
        while (en != tgt && k < 40) begin tick(1); k++; end
        if (k >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout waiting for digit enable %b", name, tgt);
        end else begin
            check(name, num, want);
        end
    endtask

    initial begin
        int masked;
        rst = 1'b1; p1 = 1'b0; p2 = 1'b0; start = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset num", num, 4'd0);
        check("reset digit_en", en, 4'b1000);
        check("reset game_over", go, 1'b0);
        check("reset winner", win, 2'b00);

        // Asynchronous reset mid-count
        tick(6);
        rst = 1'b1;
        #1;
        check("async reset digit_en", en, 4'b1000);
        check("async reset num", num, 4'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        show(4'b0100, 4'd0, "idle slot1");
        show(4'b0010, 4'd0, "idle slot2");
        show(4'b0001, 4'd0, "idle slot3");
        show(4'b1000, 4'd0, "idle slot0");

        // Points in IDLE are ignored
        point(1'b1, 1'b1);
        check("idle ignores point", m_p1 + m_p2, 0);

        // Start, then P1 held high for 5 cycles counts once
        pulse_start();
        p1 = 1'b1;
        tick(5);
        p1 = 1'b0;
        tick(1);
        check("p1 held one point", m_p1, 1);
        show(4'b0100, 4'd1, "p1 ones shows 1");
        show(4'b1000, 4'd0, "p1 tens shows 0");

        // Restart in PLAY clears, then P2 x10
        pulse_start();
        check("restart clears p1", m_p1, 0);
        repeat (10) point(1'b0, 1'b1);
        check("p2 ten points", m_p2, 10);
        show(4'b0010, 4'd1, "p2 tens shows 1");
        show(4'b0001, 4'd0, "p2 ones shows 0");

        // 10/10 then simultaneous points: tie
        repeat (10) point(1'b1, 1'b0);
        check("no game over at 10", go, 1'b0);
        p1 = 1'b1; p2 = 1'b1;
        tick(1);
        check("tie game_over", go, 1'b1);
        check("tie winner", win, 2'b11);
        p1 = 1'b0; p2 = 1'b0;
        tick(1);
        point(1'b1, 1'b0);
        point(1'b0, 1'b1);
        check("frozen p1", m_p1, 11);
        check("frozen p2", m_p2, 11);
        show(4'b1000, 4'd1, "p1 tens 1");
        show(4'b0100, 4'd1, "p1 ones 1");
        show(4'b0001, 4'd1, "p2 ones 1");

        // Start from GAME_OVER, reach 3/2, then start coincident with P1 point
        start = 1'b1;
        tick(1);
        check("restart game_over", go, 1'b0);
        check("restart winner", win, 2'b00);
        start = 1'b0;
        tick(1);
        repeat (3) point(1'b1, 1'b0);
        repeat (2) point(1'b0, 1'b1);
        check("score 3", m_p1, 3);
        start = 1'b1; p1 = 1'b1;
        tick(1);
        start = 1'b0; p1 = 1'b0;
        tick(1);
        check("start drops point p1", m_p1, 0);
        check("start drops point p2", m_p2, 0);
        point(1'b1, 1'b0);
        check("still playing", m_p1, 1);

        // P2 wins alone; default build shows no masking
        repeat (11) point(1'b0, 1'b1);
        check("p2 winner", win, 2'b10);
        check("p2 game_over", go, 1'b1);
        masked = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (en[1:0] == 2'b00) masked++;
        end
        check("no blink masking", masked, 8);

        // Reset mid-game with start held high through release
        pulse_start();
        point(1'b1, 1'b0);
        rst = 1'b1; start = 1'b1;
        #1;
        check("midgame reset game_over", go, 1'b0);
        check("midgame reset num", num, 4'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        start = 1'b0;
        tick(1);
        point(1'b1, 1'b0);
        check("post-reset p1", m_p1, 1);
        show(4'b0100, 4'd1, "post-reset p1 ones");

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
